mem_port: RTL

Word-granular main-memory model and port controller that sits directly downstream of the data cache and serves its refill reads and dirty-line write-backs. It accepts one request at a time through a valid/ready handshake and holds it for a fixed, parameterised latency. It then commits any write into an internal word array and returns exactly one response pulse carrying read data. Out-of-range detection is a build option.

---
 rtl/mem_port_if.sv | 29 ++
 rtl/mem_port.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/mem_port_if.sv
// Request/response bundle between the data cache and the main-memory port.
// The cache side uses the master modport and the memory port uses the slave modport.
// The request handshake is valid/ready. The response is a one-cycle pulse with no backpressure.
`ifndef WIDTH
`define WIDTH 32
`endif

interface mem_port_if #(
  parameter int WIDTH = `WIDTH
);
  logic               req_valid;
  logic               req_ready;
  logic [WIDTH-1:0]   req_addr;
  logic [WIDTH-1:0]   req_data;
  logic [WIDTH/8-1:0] req_mask;
  logic               resp_valid;
  logic [WIDTH-1:0]   resp_data;
  logic               resp_err;

  modport master (
    output req_valid, req_addr, req_data, req_mask,
    input  req_ready, resp_valid, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_data, req_mask,
    output req_ready, resp_valid, resp_data, resp_err
  );
endinterface

// File: rtl/mem_port.sv
// Purpose: word-granular main-memory model serving cache refills and write-backs, one request at a time.
// Latency: LATENCY cycles from the accept edge to resp_valid; peak throughput is one request per LATENCY+1 cycles.
// Backpressure: req_ready is low from the accept until the response pulse; the response itself cannot be stalled.
// Build option MEM_ADDR_CHECK_EN: flag out-of-range word indices with resp_err and drop their writes.
`ifndef WIDTH
`define WIDTH 32
`endif

module mem_port #(
  parameter int WIDTH   = `WIDTH,
  parameter int DEPTH   = 4096,
  parameter int LATENCY = 2
) (
  input  logic       clk,
  input  logic       rst,
  mem_port_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int NB = WIDTH / 8;
  localparam logic [WIDTH-1:0] ERR_WORD = WIDTH'(32'hDEAD_BEEF);

  // Elaboration guards for illegal configurations.
  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("mem_port: LATENCY must be in 1..15");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("mem_port: DEPTH must be a power of two and at least 2");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] data;
    logic [NB-1:0]    mask;
  } req_t;

  state_t           state, next_state;
  logic [3:0]       cnt;
  req_t             req_in, req_q, cur;
  logic             ready;
  logic             accept;
  logic             commit;
  logic [AW-1:0]    idx;
  logic             addr_err;
  logic [WIDTH-1:0] old_word, new_word;
  logic             resp_valid_q;
  logic             resp_err_q;
  logic [WIDTH-1:0] resp_data_q;
  logic             unused_addr;

  logic [WIDTH-1:0] mem [DEPTH];

  assign req_in = '{addr: bus.req_addr, data: bus.req_data, mask: bus.req_mask};

  // With LATENCY==1 the commit edge is the accept edge itself, so the live inputs
  // are used there; otherwise the latched copy is the source of truth.
  assign cur = (state == IDLE) ? req_in : req_q;
  assign idx = cur.addr[2 +: AW];

  // Only part of the address forms the word index; the rest is either range-checked or ignored.
  assign unused_addr = ^cur.addr;

`ifdef MEM_ADDR_CHECK_EN
  // Range check against the full word index, not just the bits that select the array.
  assign addr_err = (cur.addr >> 2) >= WIDTH'(DEPTH);
`else
  assign addr_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state decode; req_ready depends on state only, and commit marks the edge entering RESP.
  always_comb begin
    next_state = state;
    ready      = 1'b0;
    accept     = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (bus.req_valid) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            next_state = RESP;
            commit     = 1'b1;
          end else begin
            next_state = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd1) begin
          next_state = RESP;
          commit     = 1'b1;
        end
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Byte-lane merge of the write data over the currently stored word.
  always_comb begin
    old_word = mem[idx];
    new_word = old_word;
    for (int i = 0; i < NB; i++) begin
      if (cur.mask[i]) new_word[8*i +: 8] = cur.data[8*i +: 8];
    end
  end

  // Latency counter and request latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= 4'd0;
      req_q <= '0;
    end else if (accept) begin
      cnt   <= 4'(LATENCY - 1);
      req_q <= req_in;
    end else if (state == WAIT) begin
      cnt   <= cnt - 4'd1;
    end
  end

  // Word array write; contents survive reset, and rst blocks a same-edge commit.
  always_ff @(posedge clk) begin
    if (commit && !rst && !addr_err && (|cur.mask)) begin
      mem[idx] <= new_word;
    end
  end

  // Response registers: data and error are captured at the commit edge, and the pulse follows RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      resp_valid_q <= (state == RESP);
      if (commit) begin
        resp_err_q  <= addr_err;
        resp_data_q <= addr_err ? ERR_WORD : new_word;
      end
    end
  end

  assign bus.req_ready  = ready;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_err   = resp_err_q;

endmodule
